// File: rtl/axis_mask_encoder_if.sv
// AXI-Stream bundle used on both sides of the mask encoder.
// tuser is only driven on the master side; the slave modport leaves it out.
interface axis_mask_encoder_if #(
    parameter int DATA_W = 8
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tuser;

    modport master (
        output tvalid, tdata, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tlast,
        output tready
    );
endinterface

// File: rtl/axis_mask_encoder.sv
// Select-bit to mask-table encoder with a registered output stage and a skid
// register, so that s_axis.tready never depends combinationally on m_axis.tready.
module axis_mask_encoder #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    axis_mask_encoder_if.slave            s_axis,
    axis_mask_encoder_if.master           m_axis,
    input  logic [IN_WIDTH*OUT_WIDTH-1:0] masks,
    input  logic [1:0]                    mode,
    output logic [CNT_WIDTH-1:0]          zero_count,
    input  logic                          clear_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [OUT_WIDTH-1:0] r_out_data;
    logic                 r_out_last;
    logic                 r_out_user;
    logic                 r_out_vld;
    logic [OUT_WIDTH-1:0] r_skd_data;
    logic                 r_skd_last;
    logic                 r_skd_user;
    logic                 r_skd_vld;
    logic                 r_s_ready;
    logic [CNT_WIDTH-1:0] r_zero_cnt;

    logic [OUT_WIDTH-1:0] w_msb;
    logic [OUT_WIDTH-1:0] w_lsb;
    logic [OUT_WIDTH-1:0] w_or;
    logic [OUT_WIDTH-1:0] w_xor;
    logic [OUT_WIDTH-1:0] w_enc;
    logic                 w_zero;
    logic                 w_acc;
    logic                 w_out_free;
    logic                 w_skd_vld_nxt;

    assign w_zero     = (s_axis.tdata == '0);
    assign w_acc      = s_axis.tvalid && r_s_ready;
    assign w_out_free = !r_out_vld || m_axis.tready;

    // The ascending loop leaves the highest set bit's mask in w_msb,
    // the descending loop leaves the lowest in w_lsb.
    always_comb begin
        w_msb = '0;
        w_lsb = '0;
        w_or  = '0;
        w_xor = '0;
        for (int k = 0; k < IN_WIDTH; k++) begin
            if (s_axis.tdata[k]) begin
                w_msb = masks[k*OUT_WIDTH +: OUT_WIDTH];
                w_or  = w_or  | masks[k*OUT_WIDTH +: OUT_WIDTH];
                w_xor = w_xor ^ masks[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
        for (int k = IN_WIDTH - 1; k >= 0; k--) begin
            if (s_axis.tdata[k]) w_lsb = masks[k*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    always_comb begin
        w_enc = '0;
        case (mode)
            2'd0:    w_enc = w_msb;
            2'd1:    w_enc = w_lsb;
            2'd2:    w_enc = w_or;
            default: w_enc = w_xor;
        endcase
    end

    // While SKID is full tready is low, so no accept can collide with the
    // SKID->OUT move; SKID only refills from a stalled OUT.
    always_comb begin
        w_skd_vld_nxt = r_skd_vld;
        if (w_out_free) w_skd_vld_nxt = r_skd_vld && w_acc;
        else if (w_acc) w_skd_vld_nxt = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_out_user <= 1'b0;
            r_out_vld  <= 1'b0;
            r_skd_data <= '0;
            r_skd_last <= 1'b0;
            r_skd_user <= 1'b0;
            r_skd_vld  <= 1'b0;
            r_s_ready  <= 1'b0;
        end else begin
            r_skd_vld <= w_skd_vld_nxt;
            r_s_ready <= !w_skd_vld_nxt;
            if (w_out_free) begin
                if (r_skd_vld) begin
                    r_out_data <= r_skd_data;
                    r_out_last <= r_skd_last;
                    r_out_user <= r_skd_user;
                    r_out_vld  <= 1'b1;
                    if (w_acc) begin
                        r_skd_data <= w_enc;
                        r_skd_last <= s_axis.tlast;
                        r_skd_user <= w_zero;
                    end
                end else if (w_acc) begin
                    r_out_data <= w_enc;
                    r_out_last <= s_axis.tlast;
                    r_out_user <= w_zero;
                    r_out_vld  <= 1'b1;
                end else begin
                    r_out_vld  <= 1'b0;
                end
            end else if (w_acc) begin
                r_skd_data <= w_enc;
                r_skd_last <= s_axis.tlast;
                r_skd_user <= w_zero;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn)                               r_zero_cnt <= '0;
        else if (clear_count)                       r_zero_cnt <= '0;
        else if (w_acc && w_zero && r_zero_cnt != CNT_MAX) r_zero_cnt <= r_zero_cnt + 1'b1;
    end

    assign s_axis.tready = r_s_ready;
    assign m_axis.tvalid = r_out_vld;
    assign m_axis.tdata  = r_out_data;
    assign m_axis.tlast  = r_out_last;
    assign m_axis.tuser  = r_out_user;
    assign zero_count    = r_zero_cnt;

endmodule

// File: doc/axis_mask_encoder.md
Name: axis_mask_encoder

Overview:
Parametrised AXI-Stream encoder that maps a per-bit-select input word to an output word drawn from a table of per-bit masks. It is the successor to the fixed 8-bit priority encoder. It adds configurable input and output widths, four runtime-selectable combine modes, full tready backpressure through a registered skid stage, a no-bit-set flag in tuser, and a saturating zero-input counter. It sits between the byte-stream source and the downstream transmit/shift logic.

Parameters:
IN_WIDTH, 8, number of select bits in s_axis_tdata; also the number of mask entries (min 1, max 64).
OUT_WIDTH, 8, width of each mask entry and of m_axis_tdata (min 1).
CNT_WIDTH, 16, width of zero_count.

Ports:
aclk  input  1  clock; all logic on the rising edge.
aresetn  input  1  synchronous, active-low reset.
s_axis_tvalid  input  1  input beat valid.
s_axis_tready  output  1  input beat accepted when high with tvalid; registered.
s_axis_tdata  input  IN_WIDTH  select bits.
s_axis_tlast  input  1  passed through unchanged.
masks  input  IN_WIDTH*OUT_WIDTH  mask k = masks[k*OUT_WIDTH +: OUT_WIDTH].
mode  input  2  combine mode: 0 = MSB priority, 1 = LSB priority, 2 = OR, 3 = XOR.
m_axis_tvalid  output  1  output beat valid.
m_axis_tready  input  1  downstream ready.
m_axis_tdata  output  OUT_WIDTH  encoded word.
m_axis_tlast  output  1  tlast of the source beat.
m_axis_tuser  output  1  1 when the source s_axis_tdata was all zero.
zero_count  output  CNT_WIDTH  accepted all-zero beats; saturating.
clear_count  input  1  synchronous clear of zero_count.

Behaviour:
- Encode function f(d), combinational on the accepted beat. masks and mode are sampled in the same cycle as the accept; later changes do not affect beats already held.
  - Mode 0: mask of the highest set bit of d.
  - Mode 1: mask of the lowest set bit of d.
  - Mode 2: bitwise OR of the masks of all set bits.
  - Mode 3: bitwise XOR of the masks of all set bits.
  - d == 0: f = 0 in every mode; tuser = 1.
- Accept condition: s_axis_tvalid && s_axis_tready. Output transfer condition: m_axis_tvalid && m_axis_tready.
- Storage: one output register (OUT) plus one skid register (SKID). Each holds {tdata, tlast, tuser, valid}.
- Per clock, evaluated in this order:
  - If OUT is empty or transfers this cycle:
    - If SKID is valid: SKID moves to OUT, and SKID is cleared unless a new beat is accepted into it.
    - Else, if an accept occurs: f(beat) goes to OUT.
    - Else: OUT becomes empty.
  - Otherwise (OUT full and stalled): an accept loads SKID.
- s_axis_tready next value = !(SKID valid next). It deasserts only while SKID holds a beat, and never combinationally depends on m_axis_tready.
- Latency: an accepted beat appears on m_axis_* the cycle after acceptance when OUT is free. Sustained throughput is 1 beat/clock with m_axis_tready held high.
- While m_axis_tvalid is high and m_axis_tready is low, m_axis_tdata, m_axis_tlast and m_axis_tuser stay stable. Beats are delivered in order, with no loss or duplication.
- zero_count:
  - Increments by 1 on each accept with s_axis_tdata == 0.
  - Holds at 2^CNT_WIDTH-1 when saturated.
  - clear_count takes priority over a simultaneous increment; the result is 0.
- Reset (aresetn low at a clock edge):
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0, m_axis_tuser = 0.
  - SKID invalid, zero_count = 0, s_axis_tready = 0.
  - s_axis_tready rises on the first edge with aresetn high.
  - Reset mid-stream discards the OUT and SKID contents.
- No beat is accepted while s_axis_tready = 0, whatever the value of s_axis_tvalid.

Test Plan:
- Defaults, masks = 0x8877665544332211, m_axis_tready = 1, beats 0x01, 0x80, 0x12, 0x00 in mode 0 -> outputs 0x11, 0x88, 0x55, 0x00 one cycle after each accept. tuser = 1 only on the last beat. zero_count = 1.
- Same masks, beat 0x12 in modes 1, 2, 3 -> 0x22, 0x77 (0x22|0x55), 0x77 (0x22^0x55). Beat 0x03 in mode 3 -> 0x33 (0x11^0x22).
- Stream 0x01, 0x02, 0x04, 0x08 back-to-back; m_axis_tready low for 3 cycles after the first output:
  - s_axis_tready falls exactly one cycle after the skid fills.
  - Output sequence is 0x11, 0x22, 0x33, 0x44, with no loss and stable data while stalled.
- Change mode and masks in the cycle after a beat is accepted but is still stalled in OUT or SKID -> the held output keeps the old encoding.
- Send 2^CNT_WIDTH + 3 zero beats -> zero_count saturates at 0xFFFF. clear_count pulsed together with a zero beat -> zero_count = 0.
- Assert aresetn low for 1 cycle with both OUT and SKID full -> m_axis_tvalid = 0 and s_axis_tready = 0 on the next cycle. s_axis_tready = 1 one edge after release; the stalled beats are never emitted.
